match_collector: RTL
====================

Name: match_collector

Overview:
- Downstream controller and result buffer for the search stage.
- Loads the search job (pattern address/length, block address/length) and pulses the search reset.
- Repeatedly drives activate to step the search through the block, capturing every reported match address into an on-chip FIFO.
- Exposes the FIFO, match count and completion/error flags to the readout logic (UART/LED front end).

Parameters:
- AW, 8, width of all address/length fields and match addresses.
- DEPTH, 16, result FIFO depth (power of two).
- NOTFOUND, 8'hFF, value of search found that means "no further match".
- TIMEOUT, 1023, max cycles in RUN without a done rising edge before abort.

Ports:
- CLK100MHZ  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; returns block to IDLE and clears FIFO and flags.
- start  in  1  one-cycle pulse; latches job inputs and begins collection.
- p_in, pl_in, b_in, bl_in  in  AW each  job: pattern address, pattern length, block address, block length.
- srch_p, srch_pl, srch_b, srch_bl  out  AW each  latched job, driven to search p/pl/b/bl.
- srch_reset  out  1  to search reset.
- srch_activate  out  1  to search activate.
- srch_done  in  1  from search done.
- srch_found  in  AW  from search found.
- rd_en  in  1  pop request.
- rd_data  out  AW  popped match address.
- rd_valid  out  1  rd_data valid.
- count  out  log2(DEPTH)+1  FIFO occupancy.
- empty, full  out  1  FIFO status.
- busy  out  1  high in any state except IDLE and DONE.
- finished  out  1  high in DONE.
- overflow, timeout_err, param_err  out  1  sticky error flags.

Behaviour:
- Reset values:
  - All outputs 0, except empty=1.
  - srch_* fields 0.
  - State IDLE, FIFO pointers 0.
- States: IDLE, RST, RUN, CAPTURE, GAP, DONE.
- start accepted only in IDLE or DONE; ignored while busy.
- Accepted start:
  - Latches the job and clears FIFO, overflow, timeout_err and param_err.
  - Parameter check, performed in AW+1-bit arithmetic:
    - Reject if pl_in==0, bl_in<pl_in, or b_in+bl_in>2^AW.
    - Reject sets param_err and goes to DONE next cycle; search is never reset or activated.
    - Otherwise goes to RST.
- RST: srch_reset=1 for exactly one cycle, activate=0; next state RUN.
- RUN:
  - srch_activate=1; timeout counter increments each cycle.
  - Rising edge of srch_done (registered done_q; done & ~done_q) goes to CAPTURE, sampling srch_found that cycle.
  - done already high on entry does not count as an edge.
  - Counter reaching TIMEOUT sets timeout_err and goes to DONE.
- CAPTURE, single cycle, activate=0. Evaluated in priority order:
  1. found==NOTFOUND goes to DONE, no push.
  2. found outside [b, b+bl-pl] goes to DONE, no push.
  3. found equal to previous captured address (search stalled) goes to DONE, no push.
  4. FIFO full sets overflow and goes to DONE, no push.
  5. Otherwise push found, record it as previous, go to GAP.
- GAP: activate=0 for one cycle, timeout counter cleared; next state RUN, so activate re-rises and the search continues from its last address.
- DONE: activate=0, finished=1; FIFO remains readable.
- FIFO:
  - Registered read, 1-cycle latency: rd_en with !empty gives rd_data and rd_valid=1 next cycle. rd_valid is a single-cycle pulse per pop.
  - rd_en when empty is ignored (rd_valid=0, pointers unchanged).
  - Simultaneous push and pop in one cycle: both occur, count unchanged. A pop on a full FIFO in the same cycle as a CAPTURE does not prevent overflow (full is sampled before the pop).
  - Pointers wrap modulo DEPTH; count saturates naturally at DEPTH.
- Reset mid-operation (any state): next cycle IDLE, srch_activate=0, srch_reset=0, FIFO empty, flags cleared.

Test Plan:
- Job p=2, pl=2, b=0, bl=20; model search returns found 3, 9, 15, then FF on successive done edges -> one srch_reset pulse; count=3; pops yield 3, 9, 15 each 1 cycle after rd_en; finished=1; no errors.
- Job pl=0, or bl=1 with pl=2, or b=250 with bl=10 -> param_err=1, finished after 1 cycle, srch_reset and srch_activate never asserted.
- DEPTH=16; model returns 17 distinct matches 0..16 -> count=16, overflow=1, FIFO holds 0..15, address 16 dropped, DONE.
- Model never asserts done -> timeout_err=1 after TIMEOUT cycles in RUN, activate drops, count=0.
- Model returns 5 then 5 again -> single entry 5, DONE; separately, rd_en on every cycle during collection with push and pop coinciding -> count stays correct, no lost or duplicated data.
- Assert reset while in RUN with 2 entries stored -> next cycle busy=0, empty=1, activate=0; a subsequent start runs the job cleanly.

Source files
------------

// File: rtl/match_collector.sv
// Search-stage controller: loads a job, steps the search engine through the block,
// and buffers every reported match address in a small FIFO for the readout logic.
module match_collector #(
  parameter int unsigned   AW       = 8,
  parameter int unsigned   DEPTH    = 16,
  parameter logic [AW-1:0] NOTFOUND = {AW{1'b1}},
  parameter int unsigned   TIMEOUT  = 1023
) (
  input  logic                    CLK100MHZ,
  input  logic                    reset,
  input  logic                    start,
  input  logic [AW-1:0]           p_in,
  input  logic [AW-1:0]           pl_in,
  input  logic [AW-1:0]           b_in,
  input  logic [AW-1:0]           bl_in,
  output logic [AW-1:0]           srch_p,
  output logic [AW-1:0]           srch_pl,
  output logic [AW-1:0]           srch_b,
  output logic [AW-1:0]           srch_bl,
  output logic                    srch_reset,
  output logic                    srch_activate,
  input  logic                    srch_done,
  input  logic [AW-1:0]           srch_found,
  input  logic                    rd_en,
  output logic [AW-1:0]           rd_data,
  output logic                    rd_valid,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full,
  output logic                    busy,
  output logic                    finished,
  output logic                    overflow,
  output logic                    timeout_err,
  output logic                    param_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] SPAN = {1'b1, {AW{1'b0}}};
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_CAPTURE, S_GAP, S_DONE} state_t;

  state_t         state_q, state_d;
  logic           done_q;
  logic [TW-1:0]  timer_q;
  logic [AW-1:0]  found_q;
  logic [AW-1:0]  prev_q;
  logic           prev_vld_q;
  logic [AW-1:0]  job_p_q, job_pl_q, job_b_q, job_bl_q;
  logic [PW:0]    wr_ptr_q, rd_ptr_q;
  logic [AW-1:0]  rd_data_q;
  logic           rd_valid_q;
  logic           ovf_q, tmo_q, perr_q;
  logic [AW-1:0]  mem_q [DEPTH];

  logic           start_ok, job_bad, done_rise, in_range, stalled;
  logic           push, pop, set_ovf, set_tmo;
  logic [AW:0]    job_end, hi_lim;

  // Job checks use one extra bit so b+bl reaching the top of the address space is exact.
  assign job_end   = {1'b0, b_in} + {1'b0, bl_in};
  assign job_bad   = (pl_in == '0) || (bl_in < pl_in) || (job_end > SPAN);
  assign hi_lim    = {1'b0, job_b_q} + {1'b0, job_bl_q} - {1'b0, job_pl_q};
  assign in_range  = ({1'b0, found_q} >= {1'b0, job_b_q}) && ({1'b0, found_q} <= hi_lim);
  assign stalled   = prev_vld_q && (found_q == prev_q);
  assign done_rise = srch_done && !done_q;
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));
  assign pop   = rd_en && !empty && !start_ok;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    push    = 1'b0;
    set_ovf = 1'b0;
    set_tmo = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = job_bad ? S_DONE : S_RST;
      S_RST:          state_d = S_RUN;
      S_RUN: begin
        if (done_rise) begin
          state_d = S_CAPTURE;
        end else if (timer_q == TIMER_LAST) begin
          state_d = S_DONE;
          set_tmo = 1'b1;
        end
      end
      S_CAPTURE: begin
        if ((found_q == NOTFOUND) || !in_range || stalled) begin
          state_d = S_DONE;
        end else if (full) begin
          state_d = S_DONE;
          set_ovf = 1'b1;
        end else begin
          state_d = S_GAP;
          push    = 1'b1;
        end
      end
      S_GAP:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      timer_q    <= '0;
      found_q    <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      job_p_q    <= '0;
      job_pl_q   <= '0;
      job_b_q    <= '0;
      job_bl_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= srch_done;
      timer_q    <= (state_q == S_RUN) ? timer_q + 1'b1 : '0;
      rd_valid_q <= 1'b0;
      if ((state_q == S_RUN) && done_rise) found_q <= srch_found;
      if (start_ok) begin
        job_p_q    <= p_in;
        job_pl_q   <= pl_in;
        job_b_q    <= b_in;
        job_bl_q   <= bl_in;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        prev_vld_q <= 1'b0;
        ovf_q      <= 1'b0;
        tmo_q      <= 1'b0;
        perr_q     <= job_bad;
      end else begin
        if (push) begin
          wr_ptr_q   <= wr_ptr_q + 1'b1;
          prev_q     <= found_q;
          prev_vld_q <= 1'b1;
        end
        if (pop) begin
          rd_ptr_q   <= rd_ptr_q + 1'b1;
          rd_data_q  <= mem_q[rd_ptr_q[PW-1:0]];
          rd_valid_q <= 1'b1;
        end
        if (set_ovf) ovf_q <= 1'b1;
        if (set_tmo) tmo_q <= 1'b1;
      end
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge CLK100MHZ) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= found_q;
  end

  assign srch_p        = job_p_q;
  assign srch_pl       = job_pl_q;
  assign srch_b        = job_b_q;
  assign srch_bl       = job_bl_q;
  assign srch_reset    = (state_q == S_RST);
  assign srch_activate = (state_q == S_RUN);
  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign finished      = (state_q == S_DONE);
  assign overflow      = ovf_q;
  assign timeout_err   = tmo_q;
  assign param_err     = perr_q;

endmodule
